alu_seq_cc: RTL and testbench

- Parametrised, handshaked execute-stage ALU for the Y86-64 datapath.
- Adds to the single-cycle combinational ALU:
  - configurable width;
  - OR, logical shift and multiply operations;
  - an iterative multi-cycle multiplier;
  - a registered condition-code (ZF/SF/OF) register with a per-operation update enable.
- Sits between decode/register-read and the write-back path.
- Condition codes feed the cmov and jump condition logic.

---
 rtl/alu_seq_cc.sv | 198 +++++++++++++++++++
 tb/tb_alu_seq_cc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_cc.sv
// alu_seq_cc -- handshaked execute-stage ALU for the Y86-64 datapath.
//
// Single-cycle ADD/SUB/AND/XOR/OR/SHL/SHR with a registered result, an
// iterative shift-add multiplier (one multiplier bit per cycle, WIDTH
// cycles), and a registered ZF/SF/OF condition-code register that updates
// only when the completing operation was issued with set_cc=1.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  request handshake; op, a, b, set_cc sampled on accept
//   op                 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR,
//                      101 SHL, 110 SHR, 111 MUL (illegal if MUL_EN=0)
//   a, b               operands (b[log2(WIDTH)-1:0] is the shift amount)
//   set_cc             refresh condition codes when this op completes
//   out_valid/out_ready result handshake; result/ovf held while stalled
//   result, ovf        operation result and its overflow indication
//   zf, sf, of         registered condition codes
//   busy               multiply in progress
module alu_seq_cc #(
   parameter int WIDTH  = 64,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             set_cc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             zf,
   output logic             sf,
   output logic             of,
   output logic             busy
);

   localparam int SH = $clog2(WIDTH);
   localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SH-1:0]      cnt_q, cnt_d;
   logic               setcc_q, setcc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               vld_q, vld_d;
   logic               zf_q, zf_d, sf_q, sf_d, of_q, of_d;

   logic               accept;
   logic               start_mul;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_ovf;
   logic [WIDTH-1:0]   sum, diff;
   logic [SH-1:0]      shamt;
   logic [2*WIDTH-1:0] acc_nxt;

   assign in_ready  = rst_n & (state_q == IDLE) & (~vld_q | out_ready);
   assign accept    = in_valid & in_ready;
   assign start_mul = MUL_EN && (op == 3'b111);

   assign sum   = a + b;
   assign diff  = a - b;
   assign shamt = b[SH-1:0];

   // Single-cycle datapath on the live request inputs.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         3'b000: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
         end
         3'b001: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
         end
         3'b010: alu_res = a & b;
         3'b011: alu_res = a ^ b;
         3'b100: alu_res = a | b;
         3'b101: alu_res = a << shamt;
         3'b110: alu_res = a >> shamt;
         default: begin
            // Only reached as a result when the multiplier is not built.
            alu_res = '0;
            alu_ovf = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      setcc_d  = setcc_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      vld_d    = vld_q;
      zf_d     = zf_q;
      sf_d     = sf_q;
      of_d     = of_q;
      acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

      case (state_q)
         IDLE: begin
            // Transfer drains the output; a same-edge new result overrides.
            if (vld_q && out_ready)
               vld_d = 1'b0;
            if (accept) begin
               if (start_mul) begin
                  state_d  = MUL;
                  acc_d    = '0;
                  mcand_d  = {{WIDTH{1'b0}}, a};
                  mplier_d = b;
                  cnt_d    = '0;
                  setcc_d  = set_cc;
               end else begin
                  result_d = alu_res;
                  ovf_d    = alu_ovf;
                  vld_d    = 1'b1;
                  if (set_cc) begin
                     zf_d = (alu_res == '0);
                     sf_d = alu_res[WIDTH-1];
                     of_d = alu_ovf;
                  end
               end
            end
         end
         MUL: begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d  = IDLE;
               result_d = acc_nxt[WIDTH-1:0];
               ovf_d    = |acc_nxt[2*WIDTH-1:WIDTH];
               vld_d    = 1'b1;
               if (setcc_q) begin
                  zf_d = (acc_nxt[WIDTH-1:0] == '0);
                  sf_d = acc_nxt[WIDTH-1];
                  of_d = |acc_nxt[2*WIDTH-1:WIDTH];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         setcc_q  <= 1'b0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         vld_q    <= 1'b0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         setcc_q  <= setcc_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         vld_q    <= vld_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
         of_q     <= of_d;
      end
   end

   assign out_valid = vld_q;
   assign result    = result_q;
   assign ovf       = ovf_q;
   assign zf        = zf_q;
   assign sf        = sf_q;
   assign of        = of_q;
   assign busy      = (state_q == MUL);

endmodule

// File: tb/tb_alu_seq_cc.sv
// Directed bench for alu_seq_cc at WIDTH=64 with the multiplier built.
module tb_alu_seq_cc;

   localparam int W = 64;
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, XOR = 3'b011,
                          OR  = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         set_cc = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         ovf, zf, sf, of, busy;

   int checks = 0;
   int passed = 0;

   alu_seq_cc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .set_cc(set_cc), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .ovf(ovf), .zf(zf), .sf(sf),
      .of(of), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic cc);
      in_valid = 1'b1; op = o; a = x; b = y; set_cc = cc;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else passed++;
      checks++; if ({out_valid, busy, zf, sf, of, ovf} !== 6'b0)
         $display("FAIL rst_outs got %b want 000000", {out_valid, busy, zf, sf, of, ovf}); else passed++;
      checks++; if (result !== '0) $display("FAIL rst_result got %h want 0", result); else passed++;
      tick;
      rst_n = 1'b1;
      tick;
      checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_add_sub_ovf;
      drive(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      tick;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", out_valid); else passed++;
      checks++; if (result !== 64'h8000_0000_0000_0000) $display("FAIL add_result got %h want 8000000000000000", result); else passed++;
      checks++; if ({ovf, zf, sf, of} !== 4'b1011) $display("FAIL add_flags ovf/zf/sf/of got %b want 1011", {ovf, zf, sf, of}); else passed++;
      drive(SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
      tick;
      in_valid = 1'b0;
      checks++; if (result !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL sub_ovf_result got %h want 7fffffffffffffff", result); else passed++;
      checks++; if ({ovf, zf, sf, of} !== 4'b1001) $display("FAIL sub_ovf_flags got %b want 1001", {ovf, zf, sf, of}); else passed++;
      tick;
      checks++; if (out_valid !== 1'b0) $display("FAIL add_drain got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_sub_flag_hold;
      drive(SUB, 64'h1234, 64'h1234, 1'b1);
      tick;
      checks++; if (result !== '0) $display("FAIL sub_eq_result got %h want 0", result); else passed++;
      checks++; if ({ovf, zf, sf, of} !== 4'b0100) $display("FAIL sub_eq_flags got %b want 0100", {ovf, zf, sf, of}); else passed++;
      drive(AND, 64'hF0, 64'h0F, 1'b0);
      tick;
      checks++; if ({out_valid, result} !== {1'b1, 64'h0}) $display("FAIL and_result got %b/%h want 1/0", out_valid, result); else passed++;
      checks++; if ({zf, sf, of} !== 3'b100) $display("FAIL and_hold_flags got %b want 100", {zf, sf, of}); else passed++;
      drive(OR, 64'h8000_0000_0000_0000, 64'h1, 1'b0);
      tick;
      in_valid = 1'b0;
      checks++; if (result !== 64'h8000_0000_0000_0001) $display("FAIL or_result got %h want 8000000000000001", result); else passed++;
      checks++; if ({ovf, zf, sf, of} !== 4'b0100) $display("FAIL or_hold_flags got %b want 0100", {ovf, zf, sf, of}); else passed++;
      tick;
   endtask

   task automatic test_shift;
      drive(SHL, 64'd1, 64'd65, 1'b0);
      tick;
      checks++; if ({ovf, result} !== {1'b0, 64'd2}) $display("FAIL shl_mask got %b/%h want 0/2", ovf, result); else passed++;
      drive(SHR, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
      tick;
      checks++; if ({ovf, result} !== {1'b0, 64'd1}) $display("FAIL shr got %b/%h want 0/1", ovf, result); else passed++;
      drive(SHL, 64'h1234, 64'd64, 1'b0);
      tick;
      in_valid = 1'b0;
      checks++; if (result !== 64'h1234) $display("FAIL shl_zero got %h want 1234", result); else passed++;
      tick;
   endtask

   task automatic test_mul;
      int bad;
      drive(MUL, 64'd3, 64'd5, 1'b1);
      tick;
      // Garbage request during the multiply must be ignored.
      drive(ADD, 64'd100, 64'd200, 1'b1);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
         if (i != 63) tick;
      end
      checks++; if (bad !== 0) $display("FAIL mul_busy_window bad cycles got %0d want 0", bad); else passed++;
      tick;
      in_valid = 1'b0;
      checks++; if ({out_valid, busy} !== 2'b10) $display("FAIL mul_done valid/busy got %b want 10", {out_valid, busy}); else passed++;
      checks++; if ({ovf, result} !== {1'b0, 64'd15}) $display("FAIL mul_3x5 got %b/%h want 0/f", ovf, result); else passed++;
      checks++; if ({zf, sf, of} !== 3'b000) $display("FAIL mul_3x5_flags got %b want 000", {zf, sf, of}); else passed++;

      drive(MUL, 64'h8000_0000_0000_0000, 64'd2, 1'b1);
      tick;
      in_valid = 1'b0;
      repeat (64) tick;
      checks++; if ({out_valid, ovf, result} !== {2'b11, 64'd0}) $display("FAIL mul_ovf got %b/%b/%h want 1/1/0", out_valid, ovf, result); else passed++;
      checks++; if ({zf, sf, of} !== 3'b101) $display("FAIL mul_ovf_flags got %b want 101", {zf, sf, of}); else passed++;

      drive(MUL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0);
      tick;
      in_valid = 1'b0;
      repeat (64) tick;
      checks++; if ({ovf, result} !== {1'b0, 64'hFFFF_FFFE_0000_0001}) $display("FAIL mul_wide got %b/%h want 0/fffffffe00000001", ovf, result); else passed++;
      tick;
   endtask

   task automatic test_back_to_back_backpressure;
      int bad;
      out_ready = 1'b0;
      drive(XOR, 64'hFF, 64'h0F, 1'b0);
      tick;
      drive(ADD, 64'd2, 64'd3, 1'b0);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || result !== 64'hF0 || in_ready !== 1'b0) bad++;
         tick;
      end
      checks++; if (bad !== 0) $display("FAIL bp_hold bad cycles got %0d want 0", bad); else passed++;
      checks++; if (result !== 64'hF0) $display("FAIL bp_result got %h want f0", result); else passed++;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready got %b want 1", in_ready); else passed++;
      tick;
      in_valid = 1'b0;
      checks++; if ({out_valid, result} !== {1'b1, 64'd5}) $display("FAIL b2b_result got %b/%h want 1/5", out_valid, result); else passed++;
      tick;
      checks++; if ({out_valid, result} !== {1'b0, 64'd5}) $display("FAIL b2b_drain got %b/%h want 0/5", out_valid, result); else passed++;
   endtask

   task automatic test_async_reset;
      int bad;
      drive(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      tick;
      drive(MUL, 64'd3, 64'd5, 1'b1);
      tick;
      in_valid = 1'b0;
      repeat (9) tick;
      checks++; if ({busy, sf, of} !== 3'b111) $display("FAIL pre_rst busy/sf/of got %b want 111", {busy, sf, of}); else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if ({out_valid, busy, zf, sf, of, in_ready} !== 6'b0)
         $display("FAIL async_rst got %b want 000000", {out_valid, busy, zf, sf, of, in_ready}); else passed++;
      tick;
      rst_n = 1'b1;
      tick;
      checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", in_ready); else passed++;
      bad = 0;
      for (int i = 0; i < 70; i++) begin
         if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
         tick;
      end
      checks++; if (bad !== 0) $display("FAIL post_rst_quiet bad cycles got %0d want 0", bad); else passed++;
   endtask

   initial begin
      test_reset;
      test_add_sub_ovf;
      test_sub_flag_hold;
      test_shift;
      test_mul;
      test_back_to_back_backpressure;
      test_async_reset;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
